// File: rtl/cpu_pkg.sv
// Shared pipeline types: branch condition codes and branch-sequencer FSM states.
package cpu_pkg;

  typedef enum logic [1:0] {
    BR_EQ  = 2'b00,
    BR_GT  = 2'b01,
    BR_LT  = 2'b10,
    BR_RSV = 2'b11
  } br_code_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_OPND,
    ST_FLUSH
  } br_state_t;

  localparam int unsigned STAT_W   = 16;
  localparam int unsigned FLUSH_CW = 3;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition: unsigned compare of op_a against R15.
module branch_cond_eval
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  br_code_t          br_code,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_r15,
  output logic              taken
);

  always_comb begin
    taken = 1'b0;
    case (br_code)
      BR_EQ:   taken = (op_a == op_r15);
      BR_GT:   taken = (op_a >  op_r15);
      BR_LT:   taken = (op_a <  op_r15);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Branch resolution sequencer: holds the front end until operands are ready,
// resolves against R15 and redirects/flushes. Optional BRANCH_STATS_EN adds counters.
module branch_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [1:0]        br_code,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_r15,
  input  logic              op_ready,
  output logic              stall,
  output logic              flush,
  output logic              pc_sel,
  output logic [ADDR_W-1:0] pc_target,
  output logic              resolve_valid,
  output logic              resolve_taken
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_taken
`endif
);

  localparam logic [FLUSH_CW-1:0] FLUSH_LOAD = FLUSH_CW'(FLUSH_CYCLES);

  br_state_t            state_q, state_d;
  br_code_t             code_q, code_d;
  logic [ADDR_W-1:0]    target_q, target_d;
  logic [FLUSH_CW-1:0]  cnt_q, cnt_d;
  logic                 rv_q, rv_d;
  logic                 rt_q, rt_d;
  logic                 cond_taken;

  branch_cond_eval #(
    .DATA_W(DATA_W)
  ) u_cond (
    .br_code(code_q),
    .op_a   (op_a),
    .op_r15 (op_r15),
    .taken  (cond_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      code_q   <= BR_EQ;
      target_q <= '0;
      cnt_q    <= '0;
      rv_q     <= 1'b0;
      rt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      rv_q     <= rv_d;
      rt_q     <= rt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    rv_d     = 1'b0;
    rt_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (br_valid) begin
          code_d   = br_code_t'(br_code);
          target_d = br_target;
          state_d  = ST_WAIT_OPND;
        end
      end
      ST_WAIT_OPND: begin
        // Operands are sampled live on the resolving edge, never latched.
        if (op_ready) begin
          rv_d = 1'b1;
          rt_d = cond_taken;
          if (cond_taken) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q - FLUSH_CW'(1);
        if (cnt_q <= FLUSH_CW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign br_ready      = (state_q == ST_IDLE);
  assign stall         = (state_q == ST_WAIT_OPND);
  assign flush         = (state_q == ST_FLUSH);
  assign pc_sel        = (state_q == ST_FLUSH);
  assign pc_target     = target_q;
  assign resolve_valid = rv_q;
  assign resolve_taken = rt_q;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] nbr_q, ntk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nbr_q <= '0;
      ntk_q <= '0;
    end else if (rv_q) begin
      if (nbr_q != '1)          nbr_q <= nbr_q + STAT_W'(1);
      if (rt_q && ntk_q != '1)  ntk_q <= ntk_q + STAT_W'(1);
    end
  end

  assign stat_branches = nbr_q;
  assign stat_taken    = ntk_q;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: two instances (FLUSH_CYCLES 1 and 3),
// directed scenarios plus randomized branches against a cycle-phase reference model.
module tb_branch_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [2];
  logic        br_valid  [2];
  logic [1:0]  br_code   [2];
  logic [15:0] br_target [2];
  logic [15:0] op_a      [2];
  logic [15:0] op_r15    [2];
  logic        op_ready  [2];
  logic        br_ready  [2];
  logic        stall     [2];
  logic        flush     [2];
  logic        pc_sel    [2];
  logic [15:0] pc_target [2];
  logic        rvalid    [2];
  logic        rtaken    [2];
`ifdef BRANCH_STATS_EN
  logic [15:0] stat_b    [2];
  logic [15:0] stat_t    [2];
`endif

  int tests = 0;
  int fails = 0;
  int mdl_branches [2];
  int mdl_taken    [2];

  branch_sequencer #(.DATA_W(16), .ADDR_W(16), .FLUSH_CYCLES(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .br_valid(br_valid[0]), .br_ready(br_ready[0]),
    .br_code(br_code[0]), .br_target(br_target[0]), .op_a(op_a[0]), .op_r15(op_r15[0]),
    .op_ready(op_ready[0]), .stall(stall[0]), .flush(flush[0]), .pc_sel(pc_sel[0]),
    .pc_target(pc_target[0]), .resolve_valid(rvalid[0]), .resolve_taken(rtaken[0])
`ifdef BRANCH_STATS_EN
    , .stat_branches(stat_b[0]), .stat_taken(stat_t[0])
`endif
  );

  branch_sequencer #(.DATA_W(16), .ADDR_W(16), .FLUSH_CYCLES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .br_valid(br_valid[1]), .br_ready(br_ready[1]),
    .br_code(br_code[1]), .br_target(br_target[1]), .op_a(op_a[1]), .op_r15(op_r15[1]),
    .op_ready(op_ready[1]), .stall(stall[1]), .flush(flush[1]), .pc_sel(pc_sel[1]),
    .pc_target(pc_target[1]), .resolve_valid(rvalid[1]), .resolve_taken(rtaken[1])
`ifdef BRANCH_STATS_EN
    , .stat_branches(stat_b[1]), .stat_taken(stat_t[1])
`endif
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference condition: sign of the 17-bit difference gives the unsigned ordering.
  function automatic logic model_taken(input logic [1:0] code, input logic [15:0] a,
                                       input logic [15:0] r);
    logic [16:0] diff;
    diff = {1'b0, a} - {1'b0, r};
    case (code)
      2'd0:    return diff == 17'd0;
      2'd1:    return !diff[16] && (diff != 17'd0);
      2'd2:    return diff[16];
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle_check(input int d, input string tag);
    chk1({tag, "_br_ready"}, br_ready[d], 1'b1);
    chk1({tag, "_stall"},    stall[d],    1'b0);
    chk1({tag, "_flush"},    flush[d],    1'b0);
    chk1({tag, "_pc_sel"},   pc_sel[d],   1'b0);
  endtask

  task automatic check_stats(input int d, input string tag);
`ifdef BRANCH_STATS_EN
    chk16({tag, "_stat_branches"}, stat_b[d], 16'(mdl_branches[d]));
    chk16({tag, "_stat_taken"},    stat_t[d], 16'(mdl_taken[d]));
`else
    if (d < 0) $display("%s", tag);
`endif
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_branch(input int d, input logic [1:0] code, input logic [15:0] a,
                           input logic [15:0] r, input logic [15:0] tgt,
                           input int opwait, input bit poke_flush);
    logic exp_t;
    int   fc;
    fc    = (d == 0) ? 1 : 3;
    exp_t = model_taken(code, a, r);
    idle_check(d, "pre");
    br_valid[d]  = 1'b1;
    br_code[d]   = code;
    br_target[d] = tgt;
    op_a[d]      = a;
    op_r15[d]    = r;
    op_ready[d]  = (opwait == 0);
    @(posedge clk);
    for (int k = 0; k <= opwait; k++) begin
      @(negedge clk);
      br_valid[d] = 1'b0;
      chk1("wait_stall",    stall[d],    1'b1);
      chk1("wait_br_ready", br_ready[d], 1'b0);
      chk1("wait_rvalid",   rvalid[d],   1'b0);
      chk1("wait_flush",    flush[d],    1'b0);
      op_ready[d] = (k >= opwait);
    end
    @(negedge clk);
    op_ready[d] = 1'b0;
    chk1("res_rvalid", rvalid[d], 1'b1);
    chk1("res_rtaken", rtaken[d], exp_t);
    if (mdl_branches[d] < 65535) mdl_branches[d]++;
    if (exp_t && mdl_taken[d] < 65535) mdl_taken[d]++;
    if (exp_t) begin
      for (int j = 0; j < fc; j++) begin
        if (j > 0) begin
          @(negedge clk);
          chk1("fl_rvalid", rvalid[d], 1'b0);
        end
        chk1("fl_flush",    flush[d],    1'b1);
        chk1("fl_pc_sel",   pc_sel[d],   1'b1);
        chk1("fl_stall",    stall[d],    1'b0);
        chk1("fl_br_ready", br_ready[d], 1'b0);
        chk16("fl_pc_target", pc_target[d], tgt);
        br_valid[d]  = poke_flush;
        br_target[d] = ~tgt;
      end
      @(negedge clk);
      br_valid[d] = 1'b0;
      chk1("post_rvalid", rvalid[d], 1'b0);
      idle_check(d, "post");
      chk16("post_pc_target", pc_target[d], tgt);
    end else begin
      idle_check(d, "nt");
    end
  endtask

  task automatic reset_check(input int d, input string tag);
    idle_check(d, tag);
    chk1({tag, "_rvalid"}, rvalid[d], 1'b0);
    chk1({tag, "_rtaken"}, rtaken[d], 1'b0);
    chk16({tag, "_pc_target"}, pc_target[d], 16'h0000);
    mdl_branches[d] = 0;
    mdl_taken[d]    = 0;
    check_stats(d, tag);
  endtask

  task automatic reset_in_wait(input int d);
    idle_check(d, "rw_pre");
    br_valid[d]  = 1'b1;
    br_code[d]   = 2'b00;
    br_target[d] = 16'h1234;
    op_a[d]      = 16'h0007;
    op_r15[d]    = 16'h0007;
    op_ready[d]  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    br_valid[d] = 1'b0;
    chk1("rw_stall", stall[d], 1'b1);
    #2 rst_n[d] = 1'b0;
    #1 reset_check(d, "rw_rst");
    rst_n[d]    = 1'b1;
    op_ready[d] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk1("rw_no_rvalid", rvalid[d], 1'b0);
      idle_check(d, "rw_after");
    end
    op_ready[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; br_valid[d] = 1'b0; br_code[d] = 2'b00; br_target[d] = '0;
      op_a[d] = '0; op_r15[d] = '0; op_ready[d] = 1'b0;
      mdl_branches[d] = 0; mdl_taken[d] = 0;
    end
    repeat (2) @(negedge clk);
    reset_check(0, "rst0");
    reset_check(1, "rst1");
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);

    // Directed on FLUSH_CYCLES=1 instance
    do_branch(0, 2'b00, 16'h0005, 16'h0005, 16'h0040, 0, 1'b0);
    do_branch(0, 2'b10, 16'h8000, 16'h0001, 16'h0100, 0, 1'b0);
    do_branch(0, 2'b00, 16'h0003, 16'h0003, 16'h0200, 0, 1'b0);
    do_branch(0, 2'b01, 16'h0009, 16'h0002, 16'h0300, 4, 1'b0);

    // Directed on FLUSH_CYCLES=3 instance
    do_branch(1, 2'b11, 16'h0007, 16'h0007, 16'h0500, 0, 1'b0);
    do_branch(1, 2'b01, 16'h000a, 16'h0003, 16'h0abc, 0, 1'b1);

    // Reset during WAIT_OPND, then 3 taken + 2 not-taken
    reset_in_wait(0);
    reset_in_wait(1);
    do_branch(0, 2'b00, 16'h0011, 16'h0011, 16'h0010, 0, 1'b0);
    do_branch(0, 2'b01, 16'h0001, 16'h0002, 16'h0020, 0, 1'b0);
    do_branch(0, 2'b10, 16'h0001, 16'h0002, 16'h0030, 1, 1'b0);
    do_branch(0, 2'b11, 16'hffff, 16'h0000, 16'h0040, 0, 1'b0);
    do_branch(0, 2'b01, 16'hffff, 16'h0000, 16'h0050, 2, 1'b1);
    @(negedge clk);
    check_stats(0, "stats5");
`ifdef BRANCH_STATS_EN
    chk16("stats5_abs_branches", stat_b[0], 16'd5);
    chk16("stats5_abs_taken",    stat_t[0], 16'd3);
`endif

    // Randomized
    for (int i = 0; i < 60; i++) begin
      int          d;
      logic [15:0] a, r;
      d = i % 2;
      a = 16'($urandom);
      r = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      do_branch(d, 2'($urandom_range(0, 3)), a, r, 16'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        idle_check(d, "gap");
      end
    end
    @(negedge clk);
    check_stats(0, "final0");
    check_stats(1, "final1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
